// File: rtl/csa_accum_seq_if.sv
// Job/operand/result handshake bundle for csa_accum_seq.
// The master drives jobs and operands and consumes results; the slave is the accumulator.
interface csa_accum_seq_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned CNT_WIDTH = 8
) ();
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Sequential multi-operand accumulator: running total kept in carry-save form,
// resolved by a single carry-propagate add once the job's last operand arrives.
module csa_accum_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  csa_accum_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [ACC_WIDTH-1:0] carry_q, carry_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH-1:0] maj;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    x        = ACC_WIDTH'($signed(bus.in_data));
    maj      = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d   = bus.len;
          sum_d   = '0;
          carry_d = '0;
          state_d = (bus.len != '0) ? StAccum : StResolve;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          // 3:2 compression: no carry ripples across the word here
          sum_d   = sum_q ^ carry_q ^ x;
          carry_d = maj << 1;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = StResolve;
          end
        end
      end
      StResolve: begin
        result_d = sum_q + carry_q;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  // Outputs decode registered state only, so no input-to-output paths exist.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_data  = result_q;

endmodule
